// File: rtl/regfile_wr_arbiter.sv
// Two-source arbiter for the register file's single write port: CPU writeback has fixed
// priority, an I/O starvation counter forces an I/O grant, and a RAW stall covers in-flight writes.
module regfile_wr_arbiter #(
    parameter int DW         = 16,
    parameter int AW         = 4,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_req_valid,
    input  logic [AW-1:0] cpu_req_addr,
    input  logic [DW-1:0] cpu_req_data,
    output logic          cpu_req_ready,
    input  logic          io_req_valid,
    input  logic [AW-1:0] io_req_addr,
    input  logic [DW-1:0] io_req_data,
    output logic          io_req_ready,
    input  logic [AW-1:0] ra1,
    input  logic [AW-1:0] ra2,
    output logic          we3,
    output logic [AW-1:0] wa3,
    output logic [DW-1:0] wd3,
    output logic          raw_stall,
    output logic          dbg_state,
    output logic [3:0]    dbg_wait_cnt
);

    typedef enum logic {
        PRI_CPU = 1'b0,
        PRI_IO  = 1'b1
    } pri_state_e;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    pri_state_e    state_q, state_d;
    logic [3:0]    wait_cnt_q, wait_cnt_d;
    logic          we_q, we_d;
    logic [AW-1:0] wa_q, wa_d;
    logic [DW-1:0] wd_q, wd_d;

    logic          cpu_rdy;
    logic          io_rdy;
    logic          cpu_xfer;
    logic          io_xfer;
    logic          xfer;
    logic [AW-1:0] xfer_addr;
    logic [DW-1:0] xfer_data;

    // Handshake: a transfer happens on a rising edge with valid=1 and ready=1; requesters hold
    // valid/addr/data until ready. Ready depends only on both valids and the priority state.
    always_comb begin
        cpu_rdy = 1'b0;
        io_rdy  = 1'b0;
        if (reset) begin
            if (state_q == PRI_CPU) begin
                cpu_rdy = cpu_req_valid;
                io_rdy  = io_req_valid & ~cpu_req_valid;
            end else begin
                io_rdy  = io_req_valid;
                cpu_rdy = cpu_req_valid & ~io_req_valid;
            end
        end
    end

    assign cpu_xfer  = cpu_req_valid & cpu_rdy;
    assign io_xfer   = io_req_valid & io_rdy;
    assign xfer      = cpu_xfer | io_xfer;
    assign xfer_addr = cpu_xfer ? cpu_req_addr : io_req_addr;
    assign xfer_data = cpu_xfer ? cpu_req_data : io_req_data;

    // Priority flips when the counter is about to reach the limit, so the grant lands next cycle.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        state_d    = state_q;
        if (!io_req_valid || io_xfer) begin
            wait_cnt_d = 4'd0;
        end else if (wait_cnt_q != STARVE_LIM) begin
            wait_cnt_d = wait_cnt_q + 4'd1;
        end
        case (state_q)
            PRI_CPU: begin
                if (wait_cnt_d == STARVE_LIM) begin
                    state_d = PRI_IO;
                end
            end
            PRI_IO: begin
                if (io_xfer || !io_req_valid) begin
                    state_d = PRI_CPU;
                end
            end
            default: state_d = PRI_CPU;
        endcase
    end

    // r0 is hard-wired zero: the handshake completes but the write port is left untouched.
    always_comb begin
        we_d = 1'b0;
        wa_d = wa_q;
        wd_d = wd_q;
        if (xfer && (xfer_addr != '0)) begin
            we_d = 1'b1;
            wa_d = xfer_addr;
            wd_d = xfer_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= PRI_CPU;
            wait_cnt_q <= 4'd0;
            we_q       <= 1'b0;
            wa_q       <= '0;
            wd_q       <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            we_q       <= we_d;
            wa_q       <= wa_d;
            wd_q       <= wd_d;
        end
    end

    assign cpu_req_ready = cpu_rdy;
    assign io_req_ready  = io_rdy;
    assign we3           = we_q;
    assign wa3           = wa_q;
    assign wd3           = wd_q;
    assign dbg_state     = (state_q == PRI_IO);
    assign dbg_wait_cnt  = wait_cnt_q;

    // Regfile reads are not bypassed, so any read of the pending destination must wait a cycle.
    assign raw_stall = we_q & (((ra1 == wa_q) && (ra1 != '0)) ||
                               ((ra2 == wa_q) && (ra2 != '0)));

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed bench for regfile_wr_arbiter with a behavioural regfile fed from the write port.
module tb_regfile_wr_arbiter;

  localparam int DW = 16;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          cpu_req_valid, io_req_valid;
  logic [AW-1:0] cpu_req_addr, io_req_addr, ra1, ra2;
  logic [DW-1:0] cpu_req_data, io_req_data;
  logic          cpu_req_ready, io_req_ready;
  logic          we3, raw_stall, dbg_state;
  logic [AW-1:0] wa3;
  logic [DW-1:0] wd3;
  logic [3:0]    dbg_wait_cnt;

  logic [DW-1:0] rf [16] = '{default: '0};
  logic [AW+DW-1:0] exp_q [$];

  int n_checks = 0;
  int n_errors = 0;

  regfile_wr_arbiter #(.DW(DW), .AW(AW), .STARVE_MAX(4)) dut (
    .clk(clk), .reset(reset),
    .cpu_req_valid(cpu_req_valid), .cpu_req_addr(cpu_req_addr),
    .cpu_req_data(cpu_req_data), .cpu_req_ready(cpu_req_ready),
    .io_req_valid(io_req_valid), .io_req_addr(io_req_addr),
    .io_req_data(io_req_data), .io_req_ready(io_req_ready),
    .ra1(ra1), .ra2(ra2),
    .we3(we3), .wa3(wa3), .wd3(wd3), .raw_stall(raw_stall),
    .dbg_state(dbg_state), .dbg_wait_cnt(dbg_wait_cnt)
  );

  // clock / regfile model
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (we3 && wa3 != '0) rf[wa3] <= wd3;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    cpu_req_valid = 1'b0;
    io_req_valid  = 1'b0;
    cpu_req_addr  = '0;
    io_req_addr   = '0;
    cpu_req_data  = '0;
    io_req_data   = '0;
    ra1 = '0;
    ra2 = '0;
  endtask

  task automatic drive_cpu(input logic [AW-1:0] a, input logic [DW-1:0] d);
    cpu_req_valid = 1'b1;
    cpu_req_addr  = a;
    cpu_req_data  = d;
  endtask

  task automatic drive_io(input logic [AW-1:0] a, input logic [DW-1:0] d);
    io_req_valid = 1'b1;
    io_req_addr  = a;
    io_req_data  = d;
  endtask

  initial begin
    logic [AW+DW-1:0] exp_wr;

    // reset state, with both requesters valid to show readies are held low
    drive_idle();
    reset = 1'b0;
    cpu_req_valid = 1'b1;
    io_req_valid  = 1'b1;
    #3;
    check("rst_cpu_rdy", 32'(cpu_req_ready), 0);
    check("rst_io_rdy", 32'(io_req_ready), 0);
    check("rst_we3", 32'(we3), 0);
    check("rst_wa3", 32'(wa3), 0);
    check("rst_wd3", 32'(wd3), 0);
    check("rst_state", 32'(dbg_state), 0);
    check("rst_wait", 32'(dbg_wait_cnt), 0);
    check("rst_stall", 32'(raw_stall), 0);
    drive_idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;

    // single CPU write r3=BEEF
    next_cycle();
    drive_cpu(4'd3, 16'hBEEF);
    ra1 = 4'd3;
    @(negedge clk);
    check("w1_cpu_rdy", 32'(cpu_req_ready), 1);
    check("w1_io_rdy", 32'(io_req_ready), 0);
    check("w1_stall_pre", 32'(raw_stall), 0);
    next_cycle();
    cpu_req_valid = 1'b0;
    @(negedge clk);
    check("w1_we3", 32'(we3), 1);
    check("w1_wa3", 32'(wa3), 3);
    check("w1_wd3", 32'(wd3), 32'hBEEF);
    check("w1_stall_ra1", 32'(raw_stall), 1);
    ra1 = 4'd0;
    ra2 = 4'd3;
    #1;
    check("w1_stall_ra2", 32'(raw_stall), 1);
    ra2 = 4'd4;
    #1;
    check("w1_stall_miss", 32'(raw_stall), 0);
    ra1 = 4'd3;
    ra2 = 4'd0;
    next_cycle();
    @(negedge clk);
    check("w1_we3_off", 32'(we3), 0);
    check("w1_stall_post", 32'(raw_stall), 0);
    check("w1_rf3", 32'(rf[3]), 32'hBEEF);
    ra1 = 4'd0;

    // contention: io granted at cycles 4 and 9
    next_cycle();
    drive_cpu(4'd1, 16'h1111);
    drive_io(4'd2, 16'h2222);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("ct_cpu_rdy%0d", i), 32'(cpu_req_ready), (i == 4 || i == 9) ? 0 : 1);
      check($sformatf("ct_io_rdy%0d", i), 32'(io_req_ready), (i == 4 || i == 9) ? 1 : 0);
      check($sformatf("ct_state%0d", i), 32'(dbg_state), (i == 4 || i == 9) ? 1 : 0);
      check($sformatf("ct_wait%0d", i), 32'(dbg_wait_cnt), (i < 5) ? i : i - 5);
      if (i >= 1) check($sformatf("ct_wa3_%0d", i), 32'(wa3), (i == 5) ? 2 : 1);
      next_cycle();
    end
    drive_idle();
    @(negedge clk);
    check("ct_last_wa3", 32'(wa3), 2);
    check("ct_last_wd3", 32'(wd3), 32'h2222);
    check("ct_state_back", 32'(dbg_state), 0);

    // address 0 write from io
    next_cycle();
    drive_io(4'd0, 16'hFFFF);
    @(negedge clk);
    check("a0_io_rdy", 32'(io_req_ready), 1);
    next_cycle();
    io_req_valid = 1'b0;
    @(negedge clk);
    check("a0_we3", 32'(we3), 0);
    check("a0_wa3", 32'(wa3), 2);
    check("a0_wd3", 32'(wd3), 32'h2222);
    check("a0_stall", 32'(raw_stall), 0);
    check("a0_rf0", 32'(rf[0]), 0);

    // same address from both sources in the same cycle
    next_cycle();
    drive_cpu(4'd5, 16'h0001);
    drive_io(4'd5, 16'h0002);
    @(negedge clk);
    check("sa_cpu_rdy", 32'(cpu_req_ready), 1);
    check("sa_io_rdy", 32'(io_req_ready), 0);
    next_cycle();
    cpu_req_valid = 1'b0;
    @(negedge clk);
    check("sa_io_rdy2", 32'(io_req_ready), 1);
    check("sa_wd3_cpu", 32'(wd3), 32'h0001);
    next_cycle();
    io_req_valid = 1'b0;
    @(negedge clk);
    check("sa_rf5_cpu", 32'(rf[5]), 32'h0001);
    check("sa_wd3_io", 32'(wd3), 32'h0002);
    next_cycle();
    @(negedge clk);
    check("sa_rf5_io", 32'(rf[5]), 32'h0002);

    // back-to-back CPU writes r1..r8
    for (int j = 0; j <= 8; j++) begin
      next_cycle();
      if (j < 8) begin
        drive_cpu(4'(j + 1), 16'(16'h1000 + j));
        exp_q.push_back({cpu_req_addr, cpu_req_data});
      end else begin
        cpu_req_valid = 1'b0;
      end
      @(negedge clk);
      if (j < 8) check($sformatf("bb_rdy%0d", j), 32'(cpu_req_ready), 1);
      if (j >= 1) begin
        check($sformatf("bb_we3_%0d", j), 32'(we3), 1);
        exp_wr = exp_q.pop_front();
        check($sformatf("bb_wr%0d", j), 32'({wa3, wd3}), 32'(exp_wr));
      end
    end
    next_cycle();
    @(negedge clk);
    check("bb_we3_end", 32'(we3), 0);
    check("bb_q_empty", 32'(exp_q.size()), 0);
    for (int k = 1; k <= 8; k++) begin
      check($sformatf("bb_rf%0d", k), 32'(rf[k]), 32'h1000 + k - 1);
    end

    // reset asserted while a write to r7 is in flight
    next_cycle();
    drive_cpu(4'd7, 16'h7777);
    @(negedge clk);
    check("rm_cpu_rdy", 32'(cpu_req_ready), 1);
    next_cycle();
    cpu_req_valid = 1'b0;
    drive_io(4'd9, 16'h9999);
    check("rm_we3_inflight", 32'(we3), 1);
    #2;
    reset = 1'b0;
    #1;
    check("rm_we3_drop", 32'(we3), 0);
    check("rm_wa3", 32'(wa3), 0);
    check("rm_wd3", 32'(wd3), 0);
    check("rm_io_rdy", 32'(io_req_ready), 0);
    next_cycle();
    next_cycle();
    check("rm_rf7", 32'(rf[7]), 32'h1006);
    io_req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    next_cycle();
    check("rm_state", 32'(dbg_state), 0);
    check("rm_wait", 32'(dbg_wait_cnt), 0);
    check("rm_we3_after", 32'(we3), 0);

    // final report
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
